// File: rtl/move_horiz_ctrl_if.sv
// Signal bundle between the horizontal movement controller and its surroundings:
// key levels, collision stops, spawn/freeze control, and the piece position outputs.
interface move_horiz_ctrl_if;
  logic       btn_left;
  logic       btn_right;
  logic       stop_left;
  logic       stop_right;
  logic       spawn;
  logic       freeze;
  logic [9:0] ref_x;
  logic       moved;
  logic       move_dir;

  modport master (
    output btn_left, btn_right, stop_left, stop_right, spawn, freeze,
    input  ref_x, moved, move_dir
  );

  modport slave (
    input  btn_left, btn_right, stop_left, stop_right, spawn, freeze,
    output ref_x, moved, move_dir
  );
endinterface

// File: rtl/move_horiz_ctrl.sv
// Horizontal movement controller: left/right keys become one-cell moves with delayed
// auto-repeat, gated by the collision stops; owns the piece ref_x register.
module move_horiz_ctrl #(
  parameter int SIZE       = 16,
  parameter int SPAWN_X    = 288,
  parameter int DAS_CYCLES = 12500000,
  parameter int ARR_CYCLES = 2500000,
  parameter int CW         = 24
) (
  input  logic                clk,
  input  logic                rst,
  move_horiz_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, DAS, ARR} state_t;

  localparam logic [9:0]    SPAWN_POS = 10'(SPAWN_X);
  localparam logic [9:0]    STEP      = 10'(SIZE);
  localparam logic [CW-1:0] DAS_LAST  = CW'(DAS_CYCLES - 1);
  localparam logic [CW-1:0] ARR_LAST  = CW'(ARR_CYCLES - 1);

  state_t        state_reg;
  logic          adir_reg;
  logic [CW-1:0] cnt_reg;
  logic [9:0]    ref_x_reg;
  logic          moved_reg;
  logic          move_dir_reg;

  logic key_l;
  logic key_r;
  logic key_any;
  logic active_held;
  logic attempt;
  logic attempt_dir;
  logic attempt_ok;

  assign key_l       = bus.btn_left & ~bus.btn_right;
  assign key_r       = bus.btn_right & ~bus.btn_left;
  assign key_any     = key_l | key_r;
  assign active_held = adir_reg ? key_r : key_l;

  // A move is attempted on a fresh press, or when the held key's timer expires.
  always_comb begin
    attempt     = 1'b0;
    attempt_dir = adir_reg;
    case (state_reg)
      IDLE: begin
        attempt     = key_any;
        attempt_dir = key_r;
      end
      DAS:     attempt = active_held && (cnt_reg == DAS_LAST);
      ARR:     attempt = active_held && (cnt_reg == ARR_LAST);
      default: attempt = 1'b0;
    endcase
  end

  // Blocked or frozen attempts still advance the timing as if the move happened.
  assign attempt_ok = attempt && !bus.freeze && !(attempt_dir ? bus.stop_right : bus.stop_left);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      adir_reg     <= 1'b0;
      cnt_reg      <= '0;
      ref_x_reg    <= SPAWN_POS;
      moved_reg    <= 1'b0;
      move_dir_reg <= 1'b0;
    end else if (bus.spawn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ref_x_reg <= SPAWN_POS;
      moved_reg <= 1'b0;
    end else begin
      moved_reg <= attempt_ok;
      if (attempt_ok) begin
        ref_x_reg    <= attempt_dir ? (ref_x_reg + STEP) : (ref_x_reg - STEP);
        move_dir_reg <= attempt_dir;
      end

      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (key_any) begin
            adir_reg  <= key_r;
            state_reg <= DAS;
          end
        end
        DAS, ARR: begin
          if (!active_held) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else if (attempt) begin
            cnt_reg   <= '0;
            state_reg <= ARR;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.ref_x    = ref_x_reg;
  assign bus.moved    = moved_reg;
  assign bus.move_dir = move_dir_reg;

endmodule

// File: tb/tb_move_horiz_ctrl.sv
// Directed bench for move_horiz_ctrl with short DAS/ARR timing; hand-computed
// positions and move pulses are checked after every clock edge.
module tb_move_horiz_ctrl;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  move_horiz_ctrl_if bus ();

  move_horiz_ctrl #(
    .SIZE       (16),
    .SPAWN_X    (288),
    .DAS_CYCLES (4),
    .ARR_CYCLES (2),
    .CW         (24)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_pos(input string tag, input logic [15:0] x, input logic [15:0] mv);
    check({tag, ".ref_x"}, 16'(bus.ref_x), x);
    check({tag, ".moved"}, 16'(bus.moved), mv);
  endtask

  task automatic do_spawn();
    bus.spawn = 1'b1;
    tick();
    bus.spawn = 1'b0;
  endtask

  logic [11:0] t2_moves;
  logic [9:0]  t2_pos [12];

  initial begin
    compared   = 0;
    mismatched = 0;
    t2_moves   = 12'b0101_0101_0001;
    t2_pos     = '{304, 304, 304, 304, 320, 320, 336, 336, 352, 352, 368, 368};

    rst            = 1'b1;
    bus.btn_left   = 1'b0;
    bus.btn_right  = 1'b0;
    bus.stop_left  = 1'b0;
    bus.stop_right = 1'b0;
    bus.spawn      = 1'b0;
    bus.freeze     = 1'b0;
    tick();
    tick();
    check_pos("reset", 288, 0);
    check("reset.dir", 16'(bus.move_dir), 0);
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1.moved", 16'(bus.moved), 0);
    end
    check("t1.ref_x", 16'(bus.ref_x), 288);

    // 2: held right, DAS then ARR
    bus.btn_right = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_pos($sformatf("t2.c%0d", i), 16'(t2_pos[i]), 16'(t2_moves[i]));
    end
    check("t2.dir", 16'(bus.move_dir), 1);
    bus.btn_right = 1'b0;
    tick();
    check_pos("t2.release", 368, 0);
    do_spawn();
    check_pos("t2.spawn", 288, 0);

    // 3: blocked right, unblocked while in ARR
    bus.stop_right = 1'b1;
    bus.btn_right  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_pos($sformatf("t3.blk%0d", i), 288, 0);
    end
    bus.stop_right = 1'b0;
    tick();
    check_pos("t3.arr_cnt", 288, 0);
    tick();
    check_pos("t3.arr_move", 304, 1);
    bus.btn_right = 1'b0;
    tick();
    do_spawn();
    check_pos("t3.spawn", 288, 0);

    // 4: tap left then right with one-cycle gap
    bus.btn_left = 1'b1;
    tick();
    check_pos("t4.left", 272, 1);
    check("t4.dir_l", 16'(bus.move_dir), 0);
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b1;
    tick();
    check_pos("t4.gap", 272, 0);
    tick();
    check_pos("t4.right", 288, 1);
    check("t4.dir_r", 16'(bus.move_dir), 1);
    bus.btn_right = 1'b0;
    tick();
    check_pos("t4.idle", 288, 0);

    // 5: both keys held, then spawn during ARR at 352
    bus.btn_left  = 1'b1;
    bus.btn_right = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_pos($sformatf("t5.both%0d", i), 288, 0);
    end
    bus.btn_left = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check_pos("t5.at352", 352, 1);
    bus.spawn = 1'b1;
    tick();
    bus.spawn = 1'b0;
    check_pos("t5.spawn", 288, 0);
    tick();
    check_pos("t5.fresh", 304, 1);
    bus.btn_right = 1'b0;
    tick();
    do_spawn();
    check_pos("t5.respawn", 288, 0);

    // 6: freeze during held right, then async reset mid-ARR
    bus.freeze    = 1'b1;
    bus.btn_right = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_pos($sformatf("t6.frz%0d", i), 288, 0);
    end
    bus.freeze = 1'b0;
    tick();
    check_pos("t6.arr_cnt", 288, 0);
    tick();
    check_pos("t6.resume", 304, 1);
    tick();
    tick();
    check_pos("t6.arr2", 320, 1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_pos("t6.async_rst", 288, 0);
    check("t6.rst_dir", 16'(bus.move_dir), 0);
    bus.btn_right = 1'b0;
    tick();
    check_pos("t6.in_rst", 288, 0);
    rst = 1'b0;
    tick();
    check_pos("t6.after_rst", 288, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
